// File: rtl/serial_div_detector_if.sv
// Bundle for the serial divisibility detector: frame control and serial bit in,
// divisibility flag, remainder and counters out.
interface serial_div_detector_if #(
  parameter int REM_W = 2,
  parameter int CNT_W = 8
);
  logic             clr;
  logic             lsb_first;
  logic             in_valid;
  logic             in_bit;
  logic             det;
  logic [REM_W-1:0] rem;
  logic [CNT_W-1:0] len;
  logic [CNT_W-1:0] det_cnt;

  modport master (
    output clr, lsb_first, in_valid, in_bit,
    input  det, rem, len, det_cnt
  );

  modport slave (
    input  clr, lsb_first, in_valid, in_bit,
    output det, rem, len, det_cnt
  );
endinterface

// File: rtl/serial_div_detector.sv
// Serial divisibility detector: keeps the running value of an MSB- or LSB-first
// bit stream modulo DIVISOR using one conditional subtract per bit (no divider).
module serial_div_detector #(
  parameter int DIVISOR = 4,
  parameter int CNT_W   = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  serial_div_detector_if.slave bus
);
  localparam int REM_W = $clog2(DIVISOR);
  localparam logic [REM_W:0] DIV_EXT = (REM_W+1)'(DIVISOR);

  logic [REM_W-1:0] r_rem;
  logic [REM_W-1:0] r_wgt;
  logic [CNT_W-1:0] r_len;
  logic             r_mode;
  logic [CNT_W-1:0] r_det_cnt;

  logic             w_mode;
  logic [REM_W-1:0] w_rem_base;
  logic [REM_W-1:0] w_wgt_base;
  logic [CNT_W-1:0] w_len_base;
  logic [REM_W:0]   w_sum;
  logic [REM_W:0]   w_dbl;
  logic [REM_W-1:0] w_rem_next;
  logic [REM_W-1:0] w_wgt_next;
  logic [CNT_W-1:0] w_len_next;

  // A clr in the same cycle as a valid bit restarts the frame first, so the
  // update is computed from the restart values rather than the registers.
  always_comb begin
    // NOTE: every combinational output gets a value on every path, so no latch is inferred.
    w_mode     = bus.clr ? bus.lsb_first : r_mode;
    w_rem_base = bus.clr ? '0 : r_rem;
    w_wgt_base = bus.clr ? REM_W'(1) : r_wgt;
    w_len_base = bus.clr ? '0 : r_len;

    if (w_mode)
      w_sum = {1'b0, w_rem_base} + (bus.in_bit ? {1'b0, w_wgt_base} : {(REM_W+1){1'b0}});
    else
      w_sum = {w_rem_base, bus.in_bit};
    w_rem_next = (w_sum >= DIV_EXT) ? REM_W'(w_sum - DIV_EXT) : REM_W'(w_sum);

    w_dbl      = {w_wgt_base, 1'b0};
    w_wgt_next = (w_dbl >= DIV_EXT) ? REM_W'(w_dbl - DIV_EXT) : REM_W'(w_dbl);

    w_len_next = (w_len_base == '1) ? w_len_base : w_len_base + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rem     <= '0;
      r_wgt     <= REM_W'(1);
      r_len     <= '0;
      r_mode    <= 1'b0;
      r_det_cnt <= '0;
    end else if (bus.clr || bus.in_valid) begin
      // NOTE: state registers use non-blocking assignments so all of them see pre-edge values.
      r_mode <= w_mode;
      if (bus.in_valid) begin
        r_rem <= w_rem_next;
        r_wgt <= w_mode ? w_wgt_next : w_wgt_base;
        r_len <= w_len_next;
        if (w_rem_next == '0 && r_det_cnt != '1)
          r_det_cnt <= r_det_cnt + 1'b1;
      end else begin
        r_rem <= w_rem_base;
        r_wgt <= w_wgt_base;
        r_len <= w_len_base;
      end
    end
  end

  // An empty frame never flags, even though its remainder is zero.
  assign bus.det     = (r_rem == '0) && (r_len != '0);
  assign bus.rem     = r_rem;
  assign bus.len     = r_len;
  assign bus.det_cnt = r_det_cnt;
endmodule

// File: doc/serial_div_detector.md
Name: serial_div_detector

Overview:
- Serial divisibility detector, parametrised in the divisor, replacing the fixed divide-by-4 sequence FSM.
- Accepts one bit per cycle under a valid qualifier and keeps a running remainder of the number received so far, MSB-first or LSB-first (mode selectable per frame).
- Flags when the accumulated value is divisible by DIVISOR; also reports remainder, frame length and a saturating detection count.
- Sits on the serial input path, feeding downstream control logic.

Parameters:
- DIVISOR, 4, divisor; integer >= 2 (any value, not only powers of 2).
- CNT_W, 8, width of the len and det_cnt counters.
- REM_W, $clog2(DIVISOR), derived localparam; width of the remainder and weight registers.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- clr  input  1  synchronous frame restart; also latches lsb_first.
- lsb_first  input  1  frame bit order: 0 = MSB-first, 1 = LSB-first; sampled only when clr=1.
- in_valid  input  1  in_bit is accepted this cycle.
- in_bit  input  1  serial data bit.
- det  output  1  1 when the current frame is non-empty and rem == 0.
- rem  output  REM_W  current value mod DIVISOR.
- len  output  CNT_W  bits accepted in the current frame; saturating.
- det_cnt  output  CNT_W  accepted bits that produced a zero remainder since reset; saturating.

Behaviour:
- Registered state:
  - rem_q
  - w_q (LSB-first weight, 2^len mod DIVISOR)
  - len_q
  - mode_q
  - det_cnt_q
- All outputs come directly from registers or from combinational logic on registers. No input-to-output combinational path.
- Reset (rst_n=0, asynchronous): rem=0, w=1, len=0, mode=0, det_cnt=0, det=0.
- Accept condition: in_valid=1 at a rising edge. Outputs reflect the bit after that same edge (latency 1).
- MSB-first update: rem' = (2*rem + in_bit) mod DIVISOR; w is unused and holds.
- LSB-first update:
  - rem' = (rem + in_bit*w) mod DIVISOR
  - w' = (2*w) mod DIVISOR
- Arithmetic width and reduction:
  - Compute in REM_W+1 bits.
  - Reduce with a single conditional subtract. 2*rem+1 and rem+w are both below 2*DIVISOR, so one subtract is sufficient.
  - No divider is used.
- len' = len+1, saturating at 2^CNT_W-1. Once len saturates, rem and w keep updating.
- det = (rem==0) && (len!=0):
  - An empty frame never flags.
  - A leading 0 bit counts as value 0 and flags det.
- det_cnt increments on every accepted bit whose rem' == 0 and saturates at 2^CNT_W-1. It is cleared only by rst_n.
- in_valid=0: all state holds, and det holds its previous value.
- clr=1 without in_valid: rem=0, w=1, len=0, mode=lsb_first next cycle; det=0.
- clr=1 with in_valid=1 in the same cycle:
  - Restart the frame first.
  - Apply in_bit as the first bit of the new frame, using the newly sampled lsb_first.
  - Result: len=1.
- lsb_first changes without clr have no effect.
- Reset mid-frame: immediate async clear of all state. Operation resumes at the first rising edge after rst_n deasserts, in MSB-first mode.

Test Plan:
1. DIVISOR=4, MSB-first, bits 1,0,1,1,0,0 (value 44) -> rem after each bit 1,2,1,3,2,0. det=1 only after the 6th bit; det_cnt=1, len=6.
2. DIVISOR=3, MSB-first, bits 1,1,0 (values 1,3,6) -> rem 1,0,0; det high after bits 2 and 3; det_cnt=2.
3. DIVISOR=5, clr with lsb_first=1, then bits 1,0,1 (value 5) -> w 1,2,4,3; rem 1,1,0; det after bit 3.
4. DIVISOR=4, MSB-first bits 1,1 with in_valid=0 gap cycles inserted -> rem/len/det frozen during gaps. Then clr+in_valid with in_bit=0 in one cycle -> len=1, rem=0, det=1.
5. rst_n pulsed low mid-frame (asynchronously, between edges) -> rem=0, len=0, det=0, det_cnt=0 immediately; mode back to MSB-first.
6. CNT_W=3, DIVISOR=2, 9 consecutive 0 bits -> det_cnt and len both saturate at 7; det remains 1.
